// File: rtl/sync_gen_pkg.sv
// ----------------------------------------------------------------------------
// sync_pkg
// Shared types and helpers for the multi-channel sync-pulse generator.
//   state_t        : controller state (IDLE / RUN)
//   BURST_CONT     : burst_len encoding for "run until aborted"
//   PHASE_VEC_MAX  : widest packed phase vector phase_field() accepts
//   phase_field()  : extracts channel ch's phase field from the packed vector
// ----------------------------------------------------------------------------
package sync_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned BURST_CONT    = 32'd0;
   localparam int unsigned PHASE_VEC_MAX = 32'd1024;

   // Channel ch occupies bits [ch*w +: w]; the result is zero-extended to 32 bits.
   function automatic logic [31:0] phase_field(input logic [PHASE_VEC_MAX-1:0] vec,
                                               input int unsigned           ch,
                                               input int unsigned           w);
      logic [PHASE_VEC_MAX-1:0] shifted;
      logic [31:0]              mask;
      shifted = vec >> (ch * w);
      if (w >= 32'd32) begin
         mask = 32'hFFFF_FFFF;
      end else begin
         mask = (32'd1 << w) - 32'd1;
      end
      return shifted[31:0] & mask;
   endfunction

endpackage

// File: rtl/sync_gen_if.sv
// ----------------------------------------------------------------------------
// sync_gen_if
// Control/status bundle between a controller and sync_gen.
//   en, start               : global enable and launch request
//   period, pulse_w         : period-1 and pulse length (CNT_W each)
//   phase                   : NCH packed per-channel offsets
//   burst_len               : periods per burst, 0 = continuous
//   busy, done, tick, out   : status strobes and per-channel sync pulses
// master = controller side, slave = generator side.
// ----------------------------------------------------------------------------
interface sync_gen_if #(
   parameter int CNT_W   = 8,
   parameter int NCH     = 4,
   parameter int BURST_W = 8
);

   logic                   en;
   logic                   start;
   logic [CNT_W-1:0]       period;
   logic [CNT_W-1:0]       pulse_w;
   logic [NCH*CNT_W-1:0]   phase;
   logic [BURST_W-1:0]     burst_len;
   logic                   busy;
   logic                   done;
   logic                   tick;
   logic [NCH-1:0]         out;

   modport master (
      output en, start, period, pulse_w, phase, burst_len,
      input  busy, done, tick, out
   );

   modport slave (
      input  en, start, period, pulse_w, phase, burst_len,
      output busy, done, tick, out
   );

endinterface

// File: rtl/sync_gen_chan.sv
// ----------------------------------------------------------------------------
// sync_chan
// One output channel: trigger compare, width counter and registered pulse.
//   clk, rst   : clock, asynchronous active-low reset
//   run        : generator is in RUN (triggers allowed)
//   clear      : run is ending this edge; drop counter and pulse
//   cnt        : current position within the period
//   phase      : this channel's offset within the period
//   pulse_w    : pulse length in cycles
//   out        : registered sync pulse, high while the width counter is nonzero
// ----------------------------------------------------------------------------
module sync_chan
   import sync_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             clear,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] phase,
   input  logic [CNT_W-1:0] pulse_w,
   output logic             out
);

   logic [CNT_W-1:0] wcnt_r;
   logic [CNT_W-1:0] wcnt_nxt_s;
   logic             trig_s;
   logic             out_r;

   // Width counter next value: clear beats a re-trigger, re-trigger reloads (never accumulates).
   always_comb begin
      trig_s     = run && (cnt == phase);
      wcnt_nxt_s = wcnt_r;
      if (clear) begin
         wcnt_nxt_s = CNT_W'(0);
      end else if (trig_s) begin
         wcnt_nxt_s = pulse_w;
      end else if (wcnt_r != CNT_W'(0)) begin
         wcnt_nxt_s = wcnt_r - CNT_W'(1);
      end else begin
         wcnt_nxt_s = wcnt_r;
      end
   end

   // Counter and pulse registers; out follows the new counter so it tracks "counter nonzero".
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_r <= CNT_W'(0);
         out_r  <= 1'b0;
      end else begin
         wcnt_r <= wcnt_nxt_s;
         out_r  <= (wcnt_nxt_s != CNT_W'(0));
      end
   end

   assign out = out_r;

endmodule

// File: rtl/sync_gen.sv
// ----------------------------------------------------------------------------
// sync_gen
// Multi-channel sync-pulse generator with programmable period, per-channel
// phase, shared pulse width and optional fixed-length burst.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sync_gen_if.slave -- config/handshake inputs, busy/done/tick/out
// Configuration is captured only on the launching edge, so a controller may
// change the inputs freely while a run is in progress.
// ----------------------------------------------------------------------------
module sync_gen
   import sync_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int NCH     = 4,
   parameter int BURST_W = 8
) (
   input  logic      clk,
   input  logic      rst,
   sync_gen_if.slave bus
);

   state_t               state_r;
   state_t               state_nxt_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W-1:0]     cnt_nxt_s;
   logic [BURST_W-1:0]   pcnt_r;
   logic [BURST_W-1:0]   pcnt_nxt_s;
   logic                 tick_r;
   logic                 tick_nxt_s;
   logic                 done_r;
   logic                 done_nxt_s;
   logic                 busy_r;

   logic [CNT_W-1:0]     period_q_r;
   logic [CNT_W-1:0]     pulse_w_q_r;
   logic [NCH*CNT_W-1:0] phase_q_r;
   logic [BURST_W-1:0]   burst_len_q_r;

   logic                 load_s;
   logic                 clear_s;
   logic                 run_s;
   logic                 wrap_s;
   logic                 abort_s;
   logic                 last_s;
   logic [NCH-1:0]       out_s;

   // Run-condition decode shared by the FSM and the channels.
   always_comb begin
      run_s   = (state_r == RUN);
      wrap_s  = run_s && (cnt_r == period_q_r);
      abort_s = run_s && !bus.en;
      if (burst_len_q_r != BURST_W'(BURST_CONT)) begin
         // pcnt_r counts completed periods, so the final period is burst_len_q-1.
         last_s = wrap_s && (pcnt_r == (burst_len_q_r - BURST_W'(1)));
      end else begin
         last_s = 1'b0;
      end
   end

   // FSM next state, position counter, period counter and strobe decode.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      pcnt_nxt_s  = pcnt_r;
      tick_nxt_s  = 1'b0;
      done_nxt_s  = 1'b0;
      load_s      = 1'b0;
      clear_s     = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_nxt_s  = CNT_W'(0);
            pcnt_nxt_s = BURST_W'(0);
            if (bus.start && bus.en) begin
               state_nxt_s = RUN;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (abort_s) begin
               // Abort wins over a coincident completion: no done, no tick.
               state_nxt_s = IDLE;
               cnt_nxt_s   = CNT_W'(0);
               pcnt_nxt_s  = BURST_W'(0);
               clear_s     = 1'b1;
            end else if (last_s) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = CNT_W'(0);
               pcnt_nxt_s  = BURST_W'(0);
               clear_s     = 1'b1;
               tick_nxt_s  = 1'b1;
               done_nxt_s  = 1'b1;
            end else if (wrap_s) begin
               cnt_nxt_s  = CNT_W'(0);
               tick_nxt_s = 1'b1;
               if (burst_len_q_r != BURST_W'(BURST_CONT)) begin
                  pcnt_nxt_s = pcnt_r + BURST_W'(1);
               end else begin
                  pcnt_nxt_s = pcnt_r;
               end
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_W'(0);
            pcnt_nxt_s  = BURST_W'(0);
            clear_s     = 1'b1;
         end
      endcase
   end

   // Controller state, counters and status strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         cnt_r   <= CNT_W'(0);
         pcnt_r  <= BURST_W'(0);
         tick_r  <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         pcnt_r  <= pcnt_nxt_s;
         tick_r  <= tick_nxt_s;
         done_r  <= done_nxt_s;
         busy_r  <= (state_nxt_s == RUN);
      end
   end

   // Configuration snapshot taken only on the launching edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_q_r    <= CNT_W'(0);
         pulse_w_q_r   <= CNT_W'(0);
         phase_q_r     <= (NCH*CNT_W)'(0);
         burst_len_q_r <= BURST_W'(0);
      end else if (load_s) begin
         period_q_r    <= bus.period;
         pulse_w_q_r   <= bus.pulse_w;
         phase_q_r     <= bus.phase;
         burst_len_q_r <= bus.burst_len;
      end else begin
         period_q_r    <= period_q_r;
         pulse_w_q_r   <= pulse_w_q_r;
         phase_q_r     <= phase_q_r;
         burst_len_q_r <= burst_len_q_r;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic [CNT_W-1:0] phase_i_s;

      assign phase_i_s = CNT_W'(phase_field(PHASE_VEC_MAX'(phase_q_r), i, CNT_W));

      sync_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .run     (run_s),
         .clear   (clear_s),
         .cnt     (cnt_r),
         .phase   (phase_i_s),
         .pulse_w (pulse_w_q_r),
         .out     (out_s[i])
      );
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.tick = tick_r;
   assign bus.out  = out_s;

endmodule

// File: tb/tb_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_sync_gen
// Directed, table-driven bench for sync_gen. Each table record is one clock
// cycle: the inputs driven during that cycle and the outputs expected in it.
// Cycle 0 is the cycle in which the first start is driven.
// ----------------------------------------------------------------------------
module tb_sync_gen;

   logic clk;
   logic rst;

   sync_gen_if #(.CNT_W(8), .NCH(4), .BURST_W(8)) bus ();

   sync_gen #(
      .CNT_W   (8),
      .NCH     (4),
      .BURST_W (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       start;
      logic       en;
      logic       junk;
      logic [3:0] out;
      logic       tick;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[$];
   int   tests_run;
   int   fails;

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic add(input logic s, input logic e, input logic j, input logic [3:0] o,
                      input logic t, input logic b, input logic d);
      vec_t v;
      v.start = s; v.en = e; v.junk = j; v.out = o; v.tick = t; v.busy = b; v.done = d;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int cyc, input logic [3:0] o,
                        input logic t, input logic b, input logic d);
      tests_run++;
      if ({bus.out, bus.tick, bus.busy, bus.done} !== {o, t, b, d}) begin
         fails++;
         $display("FAIL %s cycle %0d: got out=%b tick=%b busy=%b done=%b, expected out=%b tick=%b busy=%b done=%b",
                  name, cyc, bus.out, bus.tick, bus.busy, bus.done, o, t, b, d);
      end
   endtask

   task automatic cfg(input logic [7:0] per, input logic [7:0] pw, input logic [7:0] p0,
                      input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3,
                      input logic [7:0] bl);
      bus.period    = per;
      bus.pulse_w   = pw;
      bus.phase     = {p3, p2, p1, p0};
      bus.burst_len = bl;
   endtask

   // Leaves the bench #1 after the rising edge that opens cycle 0.
   task automatic do_reset();
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.en    = 1'b0;
      @(posedge clk); #1;
      check("reset", 0, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic run_table(input string name);
      for (int k = 0; k < tbl.size(); k++) begin
         bus.start = tbl[k].start;
         bus.en    = tbl[k].en;
         if (tbl[k].junk) begin
            bus.period    = 8'($urandom_range(0, 255));
            bus.pulse_w   = 8'($urandom_range(0, 255));
            bus.phase     = 32'($urandom);
            bus.burst_len = 8'($urandom_range(0, 255));
         end
         @(negedge clk);
         check(name, k, tbl[k].out, tbl[k].tick, tbl[k].busy, tbl[k].done);
         @(posedge clk); #1;
      end
      tbl.delete();
      bus.start = 1'b0;
   endtask

   // Legacy 1-in-4 pattern: out[0] in 2,6,10..., tick in 5,9,..., busy from 1.
   task automatic add_legacy(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         add((c == 0), 1'b1, 1'b0,
             {3'b000, (c >= 2) && ((c - 2) % 4 == 0)},
             (c >= 5) && ((c - 1) % 4 == 0),
             (c >= 1), 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clk       = 1'b0;
      rst       = 1'b0;
      tests_run = 0;
      fails     = 0;
      cfg(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

      // Legacy equivalence, continuous.
      do_reset();
      cfg(8'd3, 8'd1, 8'd0, 8'd200, 8'd200, 8'd200, 8'd0);
      add_legacy(12);
      run_table("legacy");

      // Burst of two 5-cycle periods; config inputs scrambled after launch.
      do_reset();
      cfg(8'd4, 8'd2, 8'd0, 8'd200, 8'd200, 8'd200, 8'd2);
      add(1, 1, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 1, 4'b0000, 0, 1, 0);
      add(0, 1, 1, 4'b0001, 0, 1, 0);
      add(0, 1, 1, 4'b0001, 0, 1, 0);
      add(0, 1, 1, 4'b0000, 0, 1, 0);
      add(0, 1, 1, 4'b0000, 0, 1, 0);
      add(0, 1, 1, 4'b0000, 1, 1, 0);
      add(0, 1, 1, 4'b0001, 0, 1, 0);
      add(0, 1, 1, 4'b0001, 0, 1, 0);
      add(0, 1, 1, 4'b0000, 0, 1, 0);
      add(0, 1, 1, 4'b0000, 0, 1, 0);
      add(0, 1, 1, 4'b0000, 1, 0, 1);
      add(0, 1, 1, 4'b0000, 0, 0, 0);
      run_table("burst");

      // Phases {0,2,6,9}, period 8, width 3; ch2 wraps, ch3 out of range; then abort.
      do_reset();
      cfg(8'd7, 8'd3, 8'd0, 8'd2, 8'd6, 8'd9, 8'd0);
      add(1, 1, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 0, 4'b0000, 0, 1, 0);
      add(0, 1, 0, 4'b0001, 0, 1, 0);
      add(0, 1, 0, 4'b0001, 0, 1, 0);
      add(0, 1, 0, 4'b0011, 0, 1, 0);
      add(0, 1, 0, 4'b0010, 0, 1, 0);
      add(0, 1, 0, 4'b0010, 0, 1, 0);
      add(0, 1, 0, 4'b0000, 0, 1, 0);
      add(0, 1, 0, 4'b0100, 0, 1, 0);
      add(0, 1, 0, 4'b0100, 1, 1, 0);
      add(0, 1, 0, 4'b0101, 0, 1, 0);
      add(0, 1, 0, 4'b0001, 0, 1, 0);
      add(0, 1, 0, 4'b0011, 0, 1, 0);
      add(0, 1, 0, 4'b0010, 0, 1, 0);
      add(0, 0, 0, 4'b0010, 0, 1, 0);
      add(0, 0, 0, 4'b0000, 0, 0, 0);
      run_table("phases");

      // Abort with an ignored mid-run start, then en low blocks a start in IDLE.
      do_reset();
      cfg(8'd3, 8'd1, 8'd0, 8'd200, 8'd200, 8'd200, 8'd0);
      add_legacy(5);
      add(1, 1, 0, 4'b0000, 1, 1, 0);
      add(0, 1, 0, 4'b0001, 0, 1, 0);
      add(0, 0, 0, 4'b0000, 0, 1, 0);
      add(0, 0, 0, 4'b0000, 0, 0, 0);
      add(1, 0, 0, 4'b0000, 0, 0, 0);
      add(0, 0, 0, 4'b0000, 0, 0, 0);
      run_table("abort");

      // Pulse width beyond the period holds out high; in-flight pulses truncated at completion.
      do_reset();
      cfg(8'd2, 8'd5, 8'd0, 8'd1, 8'd3, 8'd200, 8'd2);
      add(1, 1, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 0, 4'b0000, 0, 1, 0);
      add(0, 1, 0, 4'b0001, 0, 1, 0);
      add(0, 1, 0, 4'b0011, 0, 1, 0);
      add(0, 1, 0, 4'b0011, 1, 1, 0);
      add(0, 1, 0, 4'b0011, 0, 1, 0);
      add(0, 1, 0, 4'b0011, 0, 1, 0);
      add(0, 1, 0, 4'b0000, 1, 0, 1);
      add(0, 1, 0, 4'b0000, 0, 0, 0);
      run_table("clamp");

      // Zero pulse width: ticks only, no channel ever pulses.
      do_reset();
      cfg(8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      add(1, 1, 0, 4'b0000, 0, 0, 0);
      add(0, 1, 0, 4'b0000, 0, 1, 0);
      add(0, 1, 0, 4'b0000, 0, 1, 0);
      add(0, 1, 0, 4'b0000, 1, 1, 0);
      add(0, 1, 0, 4'b0000, 0, 1, 0);
      add(0, 1, 0, 4'b0000, 1, 1, 0);
      add(0, 0, 0, 4'b0000, 0, 1, 0);
      add(0, 0, 0, 4'b0000, 0, 0, 0);
      run_table("width0");

      // Asynchronous reset in the middle of cycle 4, then the legacy sequence again.
      do_reset();
      cfg(8'd3, 8'd1, 8'd0, 8'd200, 8'd200, 8'd200, 8'd0);
      add_legacy(4);
      run_table("areset_pre");
      #3;
      check("areset_busy", 4, 4'b0000, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      #1;
      check("areset_now", 4, 4'b0000, 1'b0, 1'b0, 1'b0);
      bus.start = 1'b1;
      bus.en    = 1'b1;
      @(posedge clk); #1;
      check("areset_hold", 5, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      add_legacy(12);
      run_table("legacy_after_reset");

      // Back-to-back one-period bursts with start held high.
      do_reset();
      cfg(8'd1, 8'd1, 8'd0, 8'd200, 8'd200, 8'd200, 8'd1);
      add(1, 1, 0, 4'b0000, 0, 0, 0);
      add(1, 1, 0, 4'b0000, 0, 1, 0);
      add(1, 1, 0, 4'b0001, 0, 1, 0);
      add(1, 1, 0, 4'b0000, 1, 0, 1);
      add(1, 1, 0, 4'b0000, 0, 1, 0);
      add(1, 1, 0, 4'b0001, 0, 1, 0);
      add(1, 1, 0, 4'b0000, 1, 0, 1);
      add(0, 1, 0, 4'b0000, 0, 1, 0);
      add(0, 1, 0, 4'b0001, 0, 1, 0);
      add(0, 1, 0, 4'b0000, 1, 0, 1);
      add(0, 1, 0, 4'b0000, 0, 0, 0);
      run_table("b2b");

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/sync_gen.md
Name: sync_gen

Overview:
Parametrised multi-channel sync-pulse generator and the successor to the fixed 1-in-4 sync block. It has a programmable period, a per-channel phase offset and a shared pulse width, and runs either continuously or for a fixed burst of periods. A start/busy/done handshake lets a controller launch and track it. It drives timing strobes to downstream capture/display logic in the same clock domain.

Parameters:
CNT_W, 8, width of period, phase and pulse-width fields and of the period counter
NCH, 4, number of output channels
BURST_W, 8, width of the burst-length field and of the period-completion counter

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  global enable; low in RUN aborts the run, low in IDLE blocks start
start  input  1  launch request; sampled in IDLE only
period  input  CNT_W  cycle length minus 1 (3 gives a 4-cycle period)
pulse_w  input  CNT_W  pulse length in cycles, shared by all channels
phase  input  NCH*CNT_W  per-channel offset, channel i at bits [i*CNT_W +: CNT_W]
burst_len  input  BURST_W  number of periods to run; 0 means continuous
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on normal burst completion
tick  output  1  one-cycle pulse at each period wrap
out  output  NCH  per-channel sync pulses

Behaviour:
- Reset (rst low, asynchronous): state IDLE, cnt=0, period counter=0, all width counters=0, out=0, busy=0, done=0, tick=0. Applies immediately, mid-run included. Outputs stay low while rst is low.
- States: IDLE and RUN.
- IDLE -> RUN: at the edge where start=1 and en=1. The same edge latches period, pulse_w, phase and burst_len into *_q registers. Config inputs are ignored outside that edge.
- In RUN, cnt counts 0..period_q and then wraps to 0. The first RUN cycle has cnt=0. With period_q=0, cnt stays at 0 and the block wraps every cycle.
- tick is registered and is high in the cycle where cnt=0 following a wrap. It is not asserted in the first RUN cycle.
- Channel i:
  - When cnt==phase_q[i] in RUN, its width counter loads pulse_w_q.
  - out[i] is high while its width counter is nonzero. Latency is 1 cycle: the pulse starts the cycle after cnt==phase_q[i].
  - A pulse may extend across a wrap. A re-trigger reloads the counter and does not add to it.
  - pulse_w_q=0: the channel never pulses.
  - pulse_w_q > period_q: out[i] stays high from its first trigger until the run ends.
  - phase_q[i] > period_q: the channel never triggers and out[i] stays 0.
- Burst (burst_len_q != 0):
  - The period counter increments on each wrap.
  - At the edge where cnt==period_q and this is period number burst_len_q, the block returns to IDLE. That edge clears cnt, all width counters and out, and pulses done and tick for one cycle.
  - Pulses still in flight are truncated.
- Continuous (burst_len_q == 0): the block never completes on its own.
- Abort: en=0 in RUN causes IDLE at the next edge, with cnt, width counters and out cleared and done not pulsed. An abort takes priority over completion on the same edge.
- start while in RUN is ignored.
- A new start is accepted in the cycle where done is high, which allows back-to-back bursts.
- busy=1 exactly when state==RUN.
- All outputs are registered.

Decomposition:
- Package sync_pkg holds:
  - state enum {IDLE, RUN};
  - the burst-length encoding constant BURST_CONT=0;
  - a helper function for phase field slicing.
- Sub-module sync_chan holds one channel's width counter, trigger compare and out register. It takes cnt, phase, pulse_w, run and clear, and is instantiated NCH times in a generate loop.
- sync_gen holds the FSM, cnt, the period counter, tick, done and busy.

Test Plan:
- Legacy equivalence: NCH=1, period=3, pulse_w=1, phase=0, burst_len=0, start in cycle 0. Required: out[0] high in cycles 2, 6, 10, ...; tick high in cycles 5, 9, ...; done never asserted.
- Burst: period=4, pulse_w=2, phase0=0, burst_len=2, start in cycle 0. Required: busy high in cycles 1–10; out[0] high in cycles 2–3 and 7–8; tick high in cycles 6 and 11; done high only in cycle 11.
- Phases and clamping: period=7, pulse_w=3, phases {0, 2, 6, 9}. Required: out[1] high in cycles 4–6; out[2] high in cycles 8–10, wrapping across the period boundary; out[3] always 0.
- Abort and ignored restart: continuous run, then start pulsed in cycle 5, then en=0 in cycle 7. Required: the cycle-5 start has no effect; state is IDLE in cycle 8 with out=0, busy=0 and done=0.
- Async reset mid-run: rst low at mid-cycle 4. Required: out, busy and tick go to 0 immediately without a clock edge. After rst is released, start in cycle 0 resumes the legacy sequence.
- Back-to-back: period=1, burst_len=1, start held high. Required: done high in cycle 3 with the block already restarted; busy high in cycles 1–2 and 4–5 with a one-cycle gap in cycle 3.
